serial_add_ctrl: RTL and testbench

- Bit-serial adder sequencer. One instance of the team's one-bit full-adder cell is shared across all bit positions of a WIDTH-bit addition.
- The block loads the operands, steps the cell LSB-first for WIDTH cycles while holding the carry in a flip-flop, then presents sum, carry-out and signed overflow with a start/done handshake.
- It is the area-minimal alternative to a WIDTH-cell ripple adder. It sits between an operand-supplying controller and result consumers.

---
 rtl/serial_add_pkg.sv | 13 +
 rtl/fulladder.sv | 16 +
 rtl/serial_add_ctrl.sv | 117 +++++++++++
 tb/tb_serial_add_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder sequencer: FSM state encoding
// and the default operand width.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fulladder.sv
// One-bit full-adder cell: s = a ^ b ^ p, c = majority(a, b, p).
module fulladder (
  output logic s,
  output logic c,
  input  logic a,
  input  logic b,
  input  logic p
);

  logic w_axb;

  assign w_axb = a ^ b;
  assign s     = w_axb ^ p;
  assign c     = (a & b) | (p & w_axb);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one shared full-adder cell is stepped LSB-first
// over WIDTH cycles with the carry held in a flip-flop, start/done handshake.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int               CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_sum_next;

  fulladder u_fa (
    .s (w_s),
    .c (w_c),
    .a (r_a[0]),
    .b (r_b[0]),
    .p (r_carry)
  );

  // Written as shift-then-overwrite so it stays legal when WIDTH is 1.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_sum_next            = r_sum >> 1;
    w_sum_next[WIDTH-1]   = w_s;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end

        ST_RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_c;
          r_sum   <= w_sum_next;
          r_cnt   <= r_cnt + CNT_ONE;
          if (r_cnt == LAST_CNT) begin
            // r_carry is the carry into the MSB on this final step.
            r_cout  <= w_c;
            r_ovf   <= r_carry ^ w_c;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and model-checked bench for serial_add_ctrl (WIDTH=8 and WIDTH=1).
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       cin = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       busy, done, cout, ovf;
  logic [7:0] sum;

  logic       start1 = 1'b0;
  logic       cin1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       busy1, done1, cout1, ovf1;
  logic [0:0] sum1;

  int n_vec = 0;
  int n_err = 0;

  serial_add_ctrl #(.WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  serial_add_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  typedef struct {
    logic a;
    logic b;
    logic cin;
    logic sum;
    logic cout;
    logic ovf;
  } vec1_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} from plain integer addition and sign rules.
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic c);
    logic [8:0] f;
    logic       o;
    f = {1'b0, x} + {1'b0, y} + {8'd0, c};
    o = (x[7] == y[7]) && (f[7] != x[7]);
    return {o, f[8], f[7:0]};
  endfunction

  // Launch one operation and wait (bounded) for done; reports edges to done
  // and number of sampled cycles with busy high.
  task automatic do_op(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                       output int lat, output int busy_cyc);
    a = va; b = vb; cin = vc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_cyc = 0;
    while (!done && lat < 50) begin
      if (busy) busy_cyc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  vec_t       vecs[8];
  vec1_t      vecs1[4];
  logic [7:0] bb_a[4];
  logic [7:0] bb_b[4];
  logic [9:0] exp_r;
  int         lat, bcyc, n_done, gap;

  initial begin
    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[5] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};
    vecs[6] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'hC3, 8'h5A, 1'b0, 8'h1D, 1'b1, 1'b0};

    vecs1[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs1[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs1[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs1[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    bb_a = '{8'h12, 8'hF0, 8'h7F, 8'h81};
    bb_b = '{8'h34, 8'h20, 8'h40, 8'h81};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum",  sum,  0);
    check("rst_cout", cout, 0);
    check("rst_ovf",  ovf,  0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_no_done", done, 0);

    // Directed table
    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, lat, bcyc);
      check($sformatf("v%0d_latency", i), lat, 8);
      check($sformatf("v%0d_busy_cycles", i), bcyc, 8);
      check($sformatf("v%0d_busy_at_done", i), busy, 0);
      check($sformatf("v%0d_sum", i), sum, vecs[i].sum);
      check($sformatf("v%0d_cout", i), cout, vecs[i].cout);
      check($sformatf("v%0d_ovf", i), ovf, vecs[i].ovf);
      @(posedge clk); #1;
      check($sformatf("v%0d_done_pulse", i), done, 0);
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("v%0d_sum_hold", i), sum, vecs[i].sum);
    end

    // Start during RUN must be ignored
    a = 8'h00; b = 8'hFF; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    n_done = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 3) begin
        a = 8'h11; b = 8'h11; cin = 1'b0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        n_done++;
        check("midstart_done_latency", c, 8);
      end
    end
    check("midstart_done_count", n_done, 1);
    check("midstart_sum",  sum,  8'h00);
    check("midstart_cout", cout, 1);
    check("midstart_ovf",  ovf,  0);

    // Back-to-back with start held high
    a = bb_a[0]; b = bb_b[0]; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = bb_a[1]; b = bb_b[1];
    for (int i = 0; i < 4; i++) begin
      gap = 0;
      while (!done && gap < 50) begin
        check($sformatf("b2b%0d_not_both", i), busy & done, 0);
        @(posedge clk); #1;
        gap++;
      end
      exp_r = model(bb_a[i], bb_b[i], 1'b0);
      check($sformatf("b2b%0d_gap", i), gap, 8);
      check($sformatf("b2b%0d_busy_at_done", i), busy, 0);
      check($sformatf("b2b%0d_sum", i), sum, exp_r[7:0]);
      check($sformatf("b2b%0d_cout", i), cout, exp_r[8]);
      check($sformatf("b2b%0d_ovf", i), ovf, exp_r[9]);
      if (i == 3) start = 1'b0;
      @(posedge clk); #1;
      if (i + 2 < 4) begin
        a = bb_a[i+2]; b = bb_b[i+2];
      end
    end
    check("b2b_final_idle_busy", busy, 0);
    check("b2b_final_idle_done", done, 0);

    // Reset mid-RUN
    do_op(8'hC3, 8'h5A, 1'b0, lat, bcyc);
    check("prerst_sum", sum, 8'h1D);
    a = 8'hFF; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("prerst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_sum",  sum,  0);
    check("midrst_cout", cout, 0);
    check("midrst_ovf",  ovf,  0);
    #5;
    rst_n = 1'b1;
    n_done = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done || busy) n_done++;
    end
    check("midrst_no_activity", n_done, 0);
    do_op(8'h0A, 8'h05, 1'b0, lat, bcyc);
    check("postrst_latency", lat, 8);
    check("postrst_sum",  sum,  8'h0F);
    check("postrst_cout", cout, 0);
    check("postrst_ovf",  ovf,  0);
    @(posedge clk); #1;

    // WIDTH=1 instance
    foreach (vecs1[i]) begin
      a1 = vecs1[i].a; b1 = vecs1[i].b; cin1 = vecs1[i].cin; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      check($sformatf("w1_%0d_busy", i), busy1, 1);
      lat = 0;
      while (!done1 && lat < 10) begin
        @(posedge clk); #1;
        lat++;
      end
      check($sformatf("w1_%0d_latency", i), lat, 1);
      check($sformatf("w1_%0d_sum", i), sum1, vecs1[i].sum);
      check($sformatf("w1_%0d_cout", i), cout1, vecs1[i].cout);
      check($sformatf("w1_%0d_ovf", i), ovf1, vecs1[i].ovf);
      @(posedge clk); #1;
    end

    // Random operands against the integer model
    for (int i = 0; i < 100; i++) begin
      logic [7:0] ra, rb;
      logic       rc;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      do_op(ra, rb, rc, lat, bcyc);
      exp_r = model(ra, rb, rc);
      check($sformatf("rnd%0d_latency", i), lat, 8);
      check($sformatf("rnd%0d_result_%02h_%02h_%0d", i, ra, rb, rc),
            {22'd0, ovf, cout, sum}, {22'd0, exp_r});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
